// File: rtl/inv_sub_bytes_iter_if.sv
// Request and response valid/ready channels of the iterative InvSubBytes engine.
// The engine uses the slave view; the producer/consumer side uses the master view.
interface inv_sub_bytes_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;

    modport master (
        output in_valid, in_state, out_ready,
        input  in_ready, out_valid, out_state
    );

    modport slave (
        input  in_valid, in_state, out_ready,
        output in_ready, out_valid, out_state
    );
endinterface

// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes: substitutes BYTES_PER_CYCLE bytes of a 128-bit state
// per clock, MSB byte first, and returns the block over a valid/ready handshake.
module inv_sub_bytes_iter #(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    inv_sub_bytes_iter_if.slave bus,
    output logic                busy
);
    localparam int N  = 16 / BYTES_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    generate
        if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
              BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
            $error("BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    // Inverse S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[(255 - int'(b)) * 8 +: 8];
    endfunction

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [127:0]    data_q, data_d;
    logic            in_ready_o, out_valid_o, busy_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready_o = 1'b1;
                if (bus.in_valid) begin
                    data_d  = bus.in_state;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy_o = 1'b1;
                // Byte index cnt*BPC+k counts from the MSB end of the state.
                for (int k = 0; k < BYTES_PER_CYCLE; k++) begin
                    data_d[(15 - (int'(cnt_q) * BYTES_PER_CYCLE + k)) * 8 +: 8] =
                        inv_sbox(data_q[(15 - (int'(cnt_q) * BYTES_PER_CYCLE + k)) * 8 +: 8]);
                end
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                busy_o      = 1'b1;
                out_valid_o = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = in_ready_o;
    assign bus.out_valid = out_valid_o;
    assign bus.out_state = data_q;
    assign busy          = busy_o;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Directed bench for inv_sub_bytes_iter: latency, data, backpressure, reset and
// streaming on the default build, plus 1- and 16-byte-per-cycle builds.
module tb_inv_sub_bytes_iter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    inv_sub_bytes_iter_if ifc();
    inv_sub_bytes_iter_if if1();
    inv_sub_bytes_iter_if if16();
    logic busy4, busy1, busy16;

    inv_sub_bytes_iter #(.BYTES_PER_CYCLE(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .bus(ifc),  .busy(busy4));
    inv_sub_bytes_iter #(.BYTES_PER_CYCLE(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .bus(if1),  .busy(busy1));
    inv_sub_bytes_iter #(.BYTES_PER_CYCLE(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16), .busy(busy16));

    logic         vv;
    logic [127:0] vs;
    assign if1.in_valid   = vv;
    assign if1.in_state   = vs;
    assign if1.out_ready  = 1'b1;
    assign if16.in_valid  = vv;
    assign if16.in_state  = vs;
    assign if16.out_ready = 1'b1;

    // Forward AES S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [127:0] fwd_state(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++)
            r[127 - 8*i -: 8] = SBOX[(255 - int'(s[127 - 8*i -: 8])) * 8 +: 8];
        return r;
    endfunction

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a state for one accept edge; returns at the negedge after it.
    task automatic send(input logic [127:0] s);
        chk("send_in_ready", ifc.in_ready, 1);
        ifc.in_valid = 1'b1;
        ifc.in_state = s;
        @(posedge clk);
        @(negedge clk);
        ifc.in_valid = 1'b0;
    endtask

    task automatic wait_out(input int max, output int lat);
        lat = -1;
        for (int i = 1; i <= max; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (ifc.out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    // One full block with out_ready high; returns at the negedge after the handshake.
    task automatic xfer(input string tag, input logic [127:0] s, input logic [127:0] exp);
        int lat;
        send(s);
        wait_out(40, lat);
        chk({tag, "_latency"}, lat, 4);
        chk({tag, "_data"}, ifc.out_state, exp);
        chk({tag, "_busy"}, busy4, 1);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_in_ready_after"}, ifc.in_ready, 1);
        chk({tag, "_out_valid_after"}, ifc.out_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    int           lat, lat1, lat16, c, lastc, sent, got, seen;
    logic         acc;
    logic [127:0] a_res, st1, st16, x;
    logic [127:0] sx [8];

    initial begin
        ifc.in_valid  = 1'b0;
        ifc.in_state  = '0;
        ifc.out_ready = 1'b1;
        vv = 1'b0;
        vs = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", ifc.out_valid, 0);
        chk("rst_busy", busy4, 0);
        chk("rst_out_state", ifc.out_state, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", ifc.in_ready, 1);
        chk("rst_out_valid_rel", ifc.out_valid, 0);

        // Directed vectors
        xfer("all63", {16{8'h63}}, 128'h0);
        xfer("vec1", {4{32'h007ced16}}, {4{32'h520153ff}});
        xfer("vec0", 128'h0, {16{8'h52}});

        // Narrow and wide builds on the same vector
        vv = 1'b1;
        vs = {4{32'h007ced16}};
        @(posedge clk);
        @(negedge clk);
        vv = 1'b0;
        lat1 = -1; lat16 = -1; st1 = '0; st16 = '0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 1) begin
                chk("bpc1_busy_mid", busy1, 1);
                chk("bpc16_busy_done", busy16, 1);
            end
            if (if16.out_valid && lat16 < 0) begin lat16 = i; st16 = if16.out_state; end
            if (if1.out_valid && lat1 < 0) begin lat1 = i; st1 = if1.out_state; end
        end
        chk("bpc16_latency", lat16, 1);
        chk("bpc1_latency", lat1, 16);
        chk("bpc16_data", st16, {4{32'h520153ff}});
        chk("bpc1_data", st1, {4{32'h520153ff}});

        // Round trip through the forward S-box
        for (int n = 0; n < 1000; n++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            xfer("roundtrip", fwd_state(x), x);
        end

        // Backpressure with a competing request held on the input
        ifc.out_ready = 1'b0;
        send(128'h0);
        wait_out(40, lat);
        chk("bp_latency", lat, 4);
        a_res = ifc.out_state;
        chk("bp_data", a_res, {16{8'h52}});
        ifc.in_valid = 1'b1;
        ifc.in_state = {4{32'h007ced16}};
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_hold_valid", ifc.out_valid, 1);
            chk("bp_hold_data", ifc.out_state, a_res);
            chk("bp_hold_in_ready", ifc.in_ready, 0);
        end
        ifc.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_valid", ifc.out_valid, 0);
        chk("bp_release_in_ready", ifc.in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        ifc.in_valid = 1'b0;
        wait_out(40, lat);
        chk("bp_next_latency", lat, 4);
        chk("bp_next_data", ifc.out_state, {4{32'h520153ff}});
        @(posedge clk);
        @(negedge clk);

        // Asynchronous reset in the middle of a block
        send({16{8'h63}});
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", ifc.out_valid, 0);
        chk("midrst_busy", busy4, 0);
        chk("midrst_state", ifc.out_state, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", ifc.in_ready, 1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (ifc.out_valid) seen++;
        end
        chk("midrst_no_partial", seen, 0);
        xfer("midrst_next", {4{32'h007ced16}}, {4{32'h520153ff}});

        // Streaming with in_valid and out_ready held high
        for (int k = 0; k < 8; k++) sx[k] = {$urandom, $urandom, $urandom, $urandom};
        sent = 0; got = 0; lastc = 0;
        ifc.in_valid = 1'b1;
        ifc.in_state = fwd_state(sx[0]);
        for (c = 0; c < 120 && got < 8; c++) begin
            acc = ifc.in_ready && ifc.in_valid;
            @(posedge clk);
            @(negedge clk);
            if (acc) begin
                sent++;
                if (sent < 8) ifc.in_state = fwd_state(sx[sent]);
                else ifc.in_valid = 1'b0;
            end
            if (ifc.out_valid) begin
                chk("stream_data", ifc.out_state, sx[got]);
                if (got > 0) chk("stream_gap", c - lastc, 6);
                lastc = c;
                got++;
            end
        end
        ifc.in_valid = 1'b0;
        chk("stream_count", got, 8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
